wb_regfile: RTL and testbench

- Architectural register file at the receiving end of the writeback stage: consumes the Rw/Di/WEN write triple and serves two read ports to decode.
- Contains a per-register pending-write scoreboard: decode marks a destination busy on issue, writeback clears it.
- Decode uses the hazard output to stall.
- Sits between the writeback stage (write side) and the decode stage (read/issue side) of the 5-stage pipeline.

---
 rtl/wb_regfile.sv | 66 ++++++
 tb/tb_wb_regfile.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file with pending-write scoreboard; define REGFILE_BYPASS_EN for same-cycle write-through
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WEN,
  input  logic [AW-1:0] Rw,
  input  logic [DW-1:0] Di,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [DW-1:0] Da,
  output logic [DW-1:0] Db,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          hazard,
  output logic [AW:0]   busy_cnt
);
  logic [DW-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic wr, set, set_new, clr, hz_a, hz_b;
  assign wr = WEN && Rw != '0;
  assign set = issue_valid && issue_rd != '0;
  assign set_new = set && !busy[issue_rd];
  assign clr = wr && busy[Rw] && !(set && issue_rd == Rw);
  // Register array writes; reg 0 is never written and stays zero
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[Rw] <= Di;
    end
  end
  // Scoreboard: issue sets, writeback clears, set wins on the same register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr) busy[Rw] <= 1'b0;
      if (set) busy[issue_rd] <= 1'b1;
      busy_cnt <= busy_cnt + (AW+1)'(set_new) - (AW+1)'(clr);
    end
  end
`ifdef REGFILE_BYPASS_EN
  // Read ports with write-through; a register written this cycle is no hazard
  always_comb begin
    Da = Ra == '0 ? '0 : (wr && Ra == Rw) ? Di : regs[Ra];
    Db = Rb == '0 ? '0 : (wr && Rb == Rw) ? Di : regs[Rb];
    hz_a = Ra != '0 && busy[Ra] && !(wr && Ra == Rw);
    hz_b = Rb != '0 && busy[Rb] && !(wr && Rb == Rw);
    hazard = hz_a || hz_b;
  end
`else
  // Read ports return stored values; hazard persists through the writeback cycle
  always_comb begin
    Da = Ra == '0 ? '0 : regs[Ra];
    Db = Rb == '0 ? '0 : regs[Rb];
    hz_a = Ra != '0 && busy[Ra];
    hz_b = Rb != '0 && busy[Rb];
    hazard = hz_a || hz_b;
  end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of reads, writes, scoreboard and hazard for both bypass builds
module tb_wb_regfile;
  logic CLK = 0, RST = 0, WEN = 0, issue_valid = 0, hazard;
  logic [4:0] Rw = 0, Ra = 0, Rb = 0, issue_rd = 0;
  logic [31:0] Di = 0, Da, Db;
  logic [5:0] busy_cnt;
  int vectors = 0, miscompares = 0;
  always #5 CLK = ~CLK;
  wb_regfile dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .Rw(Rw), .Di(Di), .Ra(Ra), .Rb(Rb),
    .Da(Da), .Db(Db), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard(hazard), .busy_cnt(busy_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    WEN = 0;
    issue_valid = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    #1;
    chk("rst_cnt", 32'(busy_cnt), 0);
    tick();
    tick();
    RST = 1;
    WEN = 1; Rw = 10; Di = 32'h55; issue_valid = 1; issue_rd = 6;
    tick();
    idle();
    Ra = 10; Rb = 6;
    #1;
    chk("pre_rst_da", Da, 32'h55);
    chk("pre_rst_hz", 32'(hazard), 1);
    RST = 0;
    #1;
    chk("rst_da", Da, 0);
    chk("rst_db", Db, 0);
    chk("rst_hz", 32'(hazard), 0);
    chk("rst_cnt2", 32'(busy_cnt), 0);
    tick();
    RST = 1;
    WEN = 1; Rw = 3; Di = 32'hDEADBEEF;
    tick();
    idle();
    Ra = 3;
    #1;
    chk("wr3_da", Da, 32'hDEADBEEF);
    WEN = 1; Rw = 0; Di = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0; Ra = 0;
    #1;
    chk("r0_bypass_da", Da, 0);
    tick();
    idle();
    #1;
    chk("r0_da", Da, 0);
    chk("r0_cnt", 32'(busy_cnt), 0);
    chk("r0_hz", 32'(hazard), 0);
    issue_valid = 1; issue_rd = 5;
    tick();
    idle();
    Ra = 5; Rb = 5;
    #1;
    chk("raw_hz", 32'(hazard), 1);
    chk("raw_cnt", 32'(busy_cnt), 1);
    WEN = 1; Rw = 5; Di = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("raw_wb_hz", 32'(hazard), 0);
    chk("raw_wb_da", Da, 32'h1234);
    chk("raw_wb_db", Db, 32'h1234);
`else
    chk("raw_wb_hz", 32'(hazard), 1);
    chk("raw_wb_da", Da, 0);
    chk("raw_wb_db", Db, 0);
`endif
    tick();
    idle();
    #1;
    chk("raw_after_hz", 32'(hazard), 0);
    chk("raw_after_da", Da, 32'h1234);
    chk("raw_after_cnt", 32'(busy_cnt), 0);
    issue_valid = 1; issue_rd = 7;
    tick();
    chk("sc_cnt0", 32'(busy_cnt), 1);
    issue_valid = 1; issue_rd = 7; WEN = 1; Rw = 7; Di = 32'h77;
    tick();
    idle();
    Ra = 7; Rb = 0;
    #1;
    chk("sc_hz", 32'(hazard), 1);
    chk("sc_cnt", 32'(busy_cnt), 1);
    chk("sc_da", Da, 32'h77);
    WEN = 1; Rw = 7; Di = 32'h78;
    tick();
    idle();
    #1;
    chk("sc_clr_cnt", 32'(busy_cnt), 0);
    chk("sc_clr_hz", 32'(hazard), 0);
    issue_valid = 1; issue_rd = 4;
    tick();
    issue_rd = 9;
    tick();
    chk("mix_cnt0", 32'(busy_cnt), 2);
    issue_rd = 12; WEN = 1; Rw = 4; Di = 32'h44;
    tick();
    idle();
    Ra = 9; Rb = 0;
    #1;
    chk("mix_cnt", 32'(busy_cnt), 2);
    chk("mix_hz9", 32'(hazard), 1);
    Ra = 0; Rb = 12;
    #1;
    chk("mix_hz12", 32'(hazard), 1);
    Ra = 4; Rb = 3;
    #1;
    chk("mix_hz4", 32'(hazard), 0);
    chk("mix_da4", Da, 32'h44);
    chk("mix_db3", Db, 32'hDEADBEEF);
    issue_valid = 1; issue_rd = 9;
    tick();
    chk("waw_cnt", 32'(busy_cnt), 2);
    issue_rd = 1;
    tick();
    issue_rd = 2;
    tick();
    issue_rd = 3;
    tick();
    idle();
    Ra = 1; Rb = 2;
    #1;
    chk("ar_cnt0", 32'(busy_cnt), 5);
    chk("ar_hz0", 32'(hazard), 1);
    RST = 0;
    #1;
    chk("ar_cnt", 32'(busy_cnt), 0);
    chk("ar_hz", 32'(hazard), 0);
    Ra = 3;
    #1;
    chk("ar_da", Da, 0);
    tick();
    RST = 1;
    WEN = 1; Rw = 2; Di = 32'hAB;
    tick();
    idle();
    Ra = 2;
    #1;
    chk("ar_wb_da", Da, 32'hAB);
    chk("ar_wb_cnt", 32'(busy_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
